simplez_uart_tx: RTL and testbench



---
 rtl/simplez_uart_tx_pkg.sv | 34 +++
 rtl/simplez_uart_tx_if.sv | 12 +
 rtl/simplez_uart_tx_core.sv | 116 +++++++++++
 rtl/simplez_uart_tx.sv | 81 ++++++++
 tb/tb_simplez_uart_tx.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/simplez_uart_tx_pkg.sv
// Shared Simplez peripheral definitions: bus widths, peripheral addresses,
// status bit positions and transmitter state encodings.
package simplez_uart_tx_pkg;

  localparam int DATAW = 12;
  localparam int ADDRW = 9;

  localparam logic [ADDRW-1:0] ADDR_LED    = 9'o100;
  localparam logic [ADDRW-1:0] ADDR_TXDATA = 9'o101;
  localparam logic [ADDRW-1:0] ADDR_TXSTAT = 9'o102;

  localparam int STAT_READY = 0;
  localparam int STAT_BUSY  = 1;
  localparam int STAT_OVF   = 2;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  function automatic logic [DATAW-1:0] status_word(input logic ready,
                                                   input logic busy,
                                                   input logic ovf);
    logic [DATAW-1:0] w;
    w             = {DATAW{1'b0}};
    w[STAT_READY] = ready;
    w[STAT_BUSY]  = busy;
    w[STAT_OVF]   = ovf;
    return w;
  endfunction

endpackage

// File: rtl/simplez_uart_tx_if.sv
// Simplez external bus as seen by a memory-mapped peripheral.
interface simplez_uart_tx_if import simplez_uart_tx_pkg::*; ();
  logic [ADDRW-1:0] addr;
  logic [DATAW-1:0] data_in;
  logic             wr;
  logic             rd;
  logic             sel;
  logic [DATAW-1:0] data_out;

  modport master (output addr, data_in, wr, rd, input sel, data_out);
  modport slave  (input addr, data_in, wr, rd, output sel, data_out);
endinterface

// File: rtl/simplez_uart_tx_core.sv
// 8N1 serializer: baud counter plus IDLE/START/DATA/STOP FSM. A byte offered
// while the stop bit ends is taken immediately so frames run back-to-back.
module uart_tx_core import simplez_uart_tx_pkg::*; #(
  parameter int BAUD_DIV = 104
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] data,
  output logic       take,
  output logic       busy,
  output logic       tx
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  tx_state_t   state_r, state_s;
  logic [BW-1:0] baud_r, baud_s;
  logic [2:0]  bit_r, bit_s;
  logic [7:0]  shift_r, shift_s;
  logic        tx_r, tx_s, busy_r, baud_end_s;

  // Next-state, counters, shifter and next tx level
  always_comb begin
    state_s    = state_r;
    baud_s     = baud_r;
    bit_s      = bit_r;
    shift_s    = shift_r;
    take       = 1'b0;
    baud_end_s = (baud_r == BAUD_LAST);
    case (state_r)
      TX_IDLE: begin
        if (start) begin
          take    = 1'b1;
          state_s = TX_START;
          baud_s  = {BW{1'b0}};
          shift_s = data;
        end else begin
          state_s = TX_IDLE;
        end
      end
      TX_START: begin
        if (baud_end_s) begin
          state_s = TX_DATA;
          baud_s  = {BW{1'b0}};
          bit_s   = 3'd0;
        end else begin
          baud_s  = baud_r + BW'(1);
        end
      end
      TX_DATA: begin
        if (baud_end_s) begin
          baud_s  = {BW{1'b0}};
          shift_s = {1'b0, shift_r[7:1]};
          if (bit_r == 3'd7) begin
            state_s = TX_STOP;
          end else begin
            bit_s   = bit_r + 3'd1;
          end
        end else begin
          baud_s  = baud_r + BW'(1);
        end
      end
      TX_STOP: begin
        if (baud_end_s) begin
          baud_s = {BW{1'b0}};
          if (start) begin
            take    = 1'b1;
            state_s = TX_START;
            shift_s = data;
          end else begin
            state_s = TX_IDLE;
          end
        end else begin
          baud_s = baud_r + BW'(1);
        end
      end
      default: begin
        state_s = TX_IDLE;
        baud_s  = {BW{1'b0}};
        bit_s   = 3'd0;
      end
    endcase
    case (state_s)
      TX_IDLE:  tx_s = 1'b1;
      TX_START: tx_s = 1'b0;
      TX_DATA:  tx_s = shift_s[0];
      TX_STOP:  tx_s = 1'b1;
      default:  tx_s = 1'b1;
    endcase
  end

  // State register; tx and busy come straight from flops
  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= TX_IDLE;
      baud_r  <= {BW{1'b0}};
      bit_r   <= 3'd0;
      shift_r <= 8'd0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
      busy_r  <= (state_s != TX_IDLE);
    end
  end

  assign tx   = tx_r;
  assign busy = busy_r;

endmodule

// File: rtl/simplez_uart_tx.sv
// Simplez UART transmit peripheral: address decode, 4-byte FIFO, sticky
// overflow flag and status word in front of the serializer core.
module simplez_uart_tx import simplez_uart_tx_pkg::*; #(
  parameter int BAUD_DIV = 104,
  parameter int FIFO_AW  = 2
) (
  input  logic              clk,
  input  logic              rstn,
  simplez_uart_tx_if.slave  bus,
  output logic              tx,
  output logic              busy
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  logic [7:0]         mem_r [DEPTH];
  logic [FIFO_AW-1:0] wptr_r, rptr_r;
  logic [FIFO_AW:0]   cnt_r;
  logic               ovf_r;
  logic               wr_hit_s, full_s, empty_s, push_s, pop_s, ovf_set_s, ovf_clr_s;
  logic               unused_s;

  assign wr_hit_s  = bus.wr && (bus.addr == ADDR_TXDATA);
  assign full_s    = (cnt_r == FULL_CNT);
  assign empty_s   = (cnt_r == {(FIFO_AW + 1){1'b0}});
  assign push_s    = wr_hit_s && !full_s;
  assign ovf_set_s = wr_hit_s && full_s;
  assign ovf_clr_s = bus.rd && (bus.addr == ADDR_TXSTAT);
  assign unused_s  = ^bus.data_in[DATAW-1:8];

  assign bus.sel = (bus.addr == ADDR_TXDATA) || (bus.addr == ADDR_TXSTAT);

  // Status word is visible only at its own address
  always_comb begin
    if (bus.addr == ADDR_TXSTAT) begin
      bus.data_out = status_word(!full_s, busy, ovf_r);
    end else begin
      bus.data_out = {DATAW{1'b0}};
    end
  end

  // FIFO storage; contents are don't-care while the count says empty
  always_ff @(negedge clk) begin
    if (push_s) begin
      mem_r[wptr_r] <= bus.data_in[7:0];
    end
  end

  // FIFO pointers, occupancy and overflow flag (set beats clear)
  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_r <= {FIFO_AW{1'b0}};
      rptr_r <= {FIFO_AW{1'b0}};
      cnt_r  <= {(FIFO_AW + 1){1'b0}};
      ovf_r  <= 1'b0;
    end else begin
      if (push_s) wptr_r <= wptr_r + FIFO_AW'(1);
      if (pop_s)  rptr_r <= rptr_r + FIFO_AW'(1);
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + (FIFO_AW + 1)'(1);
        2'b01:   cnt_r <= cnt_r - (FIFO_AW + 1)'(1);
        default: cnt_r <= cnt_r;
      endcase
      if (ovf_set_s)      ovf_r <= 1'b1;
      else if (ovf_clr_s) ovf_r <= 1'b0;
      else                ovf_r <= ovf_r;
    end
  end

  uart_tx_core #(.BAUD_DIV(BAUD_DIV)) u_core (
    .clk   (clk),
    .rstn  (rstn),
    .start (!empty_s),
    .data  (mem_r[rptr_r]),
    .take  (pop_s),
    .busy  (busy),
    .tx    (tx)
  );

endmodule

// File: tb/tb_simplez_uart_tx.sv
// Scoreboard bench: stimulus queues expected bytes, a serial monitor decodes
// frames from tx and compares them against the queue.
module tb_simplez_uart_tx;
  import simplez_uart_tx_pkg::*;

  localparam int BD = 4;

  logic clk = 1'b1;
  logic rstn = 1'b0;
  logic tx, busy;
  simplez_uart_tx_if bus();

  simplez_uart_tx #(.BAUD_DIV(BD), .FIFO_AW(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus),
    .tx   (tx),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int frames = 0;
  int starts[$];
  logic [7:0] exp_q[$];
  bit mon_abort = 1'b0;

  always @(negedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [8:0] a, input logic [11:0] d, input logic w, input logic r);
    @(posedge clk);
    bus.addr = a; bus.data_in = d; bus.wr = w; bus.rd = r;
  endtask

  task automatic status_is(input string name, input logic [11:0] exp);
    drive(ADDR_TXSTAT, 12'h000, 1'b0, 1'b0);
    #1 check(name, 32'(bus.data_out), 32'(exp));
  endtask

  // Serial monitor: sample mid-bit, rebuild byte, compare with queue head
  initial begin
    logic [7:0] b;
    bit abort;
    forever begin
      @(posedge clk);
      if (rstn && tx == 1'b0) begin
        frames++;
        starts.push_back(cyc);
        b = 8'h00;
        abort = 1'b0;
        for (int i = 0; i < 10 && !abort; i++) begin
          if (i == 0) @(posedge clk);
          else repeat (BD) @(posedge clk);
          if (mon_abort) begin
            abort = 1'b1;
          end else begin
            if (i == 0) check("start_bit", 32'(tx), 32'd0);
            else if (i < 9) b[i-1] = tx;
            else check("stop_bit", 32'(tx), 32'd1);
            check("busy_in_frame", 32'(busy), 32'd1);
          end
        end
        if (abort) begin
          mon_abort = 1'b0;
        end else if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'(b), 32'hFFFF_FFFF);
        end else begin
          check("frame_byte", 32'(b), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int base, fb;
    bit seen;
    bus.addr = 9'o000; bus.data_in = 12'h000; bus.wr = 1'b0; bus.rd = 1'b0;
    repeat (3) @(posedge clk);
    rstn = 1'b1;

    // idle after reset
    repeat (50) drive(9'o000, 12'h000, 1'b0, 1'b0);
    #1;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_sel", 32'(bus.sel), 32'd0);
    status_is("reset_status", 12'o0001);

    // single byte: latency and frame
    exp_q.push_back(8'hA5);
    drive(ADDR_TXDATA, 12'h7A5, 1'b1, 1'b0);
    drive(9'o000, 12'h000, 1'b0, 1'b0);
    #1 check("latency_edge_n", 32'(tx), 32'd1);
    drive(9'o000, 12'h000, 1'b0, 1'b0);
    #1 check("latency_edge_n1", 32'(tx), 32'd0);
    status_is("status_busy", 12'o0003);
    repeat (45) drive(9'o000, 12'h000, 1'b0, 1'b0);
    #1 check("after_frame_busy", 32'(busy), 32'd0);

    // six back-to-back writes: 0x06 overflows
    base = starts.size();
    for (int k = 1; k <= 5; k++) exp_q.push_back(8'(k));
    for (int k = 1; k <= 6; k++) drive(ADDR_TXDATA, 12'(k), 1'b1, 1'b0);
    status_is("status_full_ovf", 12'o0006);
    drive(ADDR_TXSTAT, 12'h000, 1'b0, 1'b1);
    #1 check("ovf_during_read", 32'(bus.data_out), 32'o0006);
    status_is("ovf_cleared", 12'o0002);
    repeat (220) drive(9'o000, 12'h000, 1'b0, 1'b0);
    check("b2b_frame_count", 32'(starts.size() - base), 32'd5);
    for (int k = 1; k < 5 && base + k < starts.size(); k++)
      check("b2b_spacing", 32'(starts[base+k] - starts[base+k-1]), 32'(10 * BD));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    status_is("status_after_b2b", 12'o0001);

    // reset in the middle of bit 3
    drive(ADDR_TXDATA, 12'h011, 1'b1, 1'b0);
    drive(ADDR_TXDATA, 12'h022, 1'b1, 1'b0);
    drive(ADDR_TXDATA, 12'h033, 1'b1, 1'b0);
    drive(9'o000, 12'h000, 1'b0, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(posedge clk);
      if (tx == 1'b0) seen = 1'b1;
    end
    check("abort_frame_started", 32'(seen), 32'd1);
    repeat (17) @(posedge clk);
    #2 mon_abort = 1'b1;
    rstn = 1'b0;
    #1;
    check("midframe_reset_tx", 32'(tx), 32'd1);
    check("midframe_reset_busy", 32'(busy), 32'd0);
    @(posedge clk);
    rstn = 1'b1;
    fb = frames;
    repeat (200) drive(9'o000, 12'h000, 1'b0, 1'b0);
    #1;
    check("no_frames_after_reset", 32'(frames), 32'(fb));
    check("idle_tx_after_reset", 32'(tx), 32'd1);
    status_is("status_after_reset", 12'o0001);

    // decode and ignored accesses
    drive(ADDR_LED, 12'h000, 1'b0, 1'b0);
    #1 check("sel_led", 32'(bus.sel), 32'd0);
    drive(ADDR_TXDATA, 12'h000, 1'b0, 1'b1);
    #1 check("sel_txdata", 32'(bus.sel), 32'd1);
    check("dout_txdata", 32'(bus.data_out), 32'd0);
    drive(ADDR_TXSTAT, 12'h000, 1'b0, 1'b0);
    #1 check("sel_txstat", 32'(bus.sel), 32'd1);
    fb = frames;
    drive(ADDR_LED, 12'h055, 1'b1, 1'b0);
    drive(ADDR_TXSTAT, 12'h0AA, 1'b1, 1'b0);
    repeat (20) drive(9'o000, 12'h000, 1'b0, 1'b0);
    #1;
    check("other_writes_tx", 32'(tx), 32'd1);
    check("other_writes_busy", 32'(busy), 32'd0);
    check("other_writes_frames", 32'(frames), 32'(fb));
    status_is("other_writes_status", 12'o0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
